// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions: writeback result select encoding and
// load funct3 codes, plus small extension helpers used by the load path.
package riscv_pkg;

   typedef enum logic [1:0] {
      WB_SEL_ALU  = 2'b00,
      WB_SEL_LOAD = 2'b01,
      WB_SEL_PC4  = 2'b10,
      WB_SEL_RSVD = 2'b11
   } wb_sel_e;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   function automatic logic [31:0] ext_byte(input logic [7:0] b, input logic is_signed);
      return {{24{is_signed & b[7]}}, b};
   endfunction

   function automatic logic [31:0] ext_half(input logic [15:0] h, input logic is_signed);
      return {{16{is_signed & h[15]}}, h};
   endfunction

endpackage

// File: rtl/load_extend.sv
// Combinational load aligner/extender: picks a byte or halfword out of an
// aligned memory word and sign- or zero-extends it according to funct3.
module load_extend
   import riscv_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  offset,
   input  logic [2:0]  funct3,
   output logic [31:0] value
);

   logic [7:0]  byte_lane [4];
   logic [15:0] half_lane [2];
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_byte_lane
         assign byte_lane[gi] = word[8*gi +: 8];
      end
      for (gi = 0; gi < 2; gi++) begin : g_half_lane
         assign half_lane[gi] = word[16*gi +: 16];
      end
   endgenerate

   // Halfword accesses use only offset[1]; a misaligned bit 0 is ignored.
   assign byte_sel = byte_lane[offset];
   assign half_sel = half_lane[offset[1]];

   always_comb begin
      value = word;
      case (funct3)
         F3_LB:   value = ext_byte(byte_sel, 1'b1);
         F3_LBU:  value = ext_byte(byte_sel, 1'b0);
         F3_LH:   value = ext_half(half_sel, 1'b1);
         F3_LHU:  value = ext_half(half_sel, 1'b0);
         F3_LW:   value = word;
         default: value = word;
      endcase
   end

endmodule

// File: rtl/wb_stage.sv
// Writeback pipeline stage: selects and extends the result, registers it for
// the register-file write port, and optionally counts retired instructions
// (retire counter present only when WB_RETIRE_COUNT_EN is defined).
module wb_stage
   import riscv_pkg::*;
#(
   parameter int CNT_W = 64
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             mem_valid,
   input  logic             mem_stall,
   input  logic             flush,
   input  logic             RegWrite_in,
   input  logic [4:0]       rd_in,
   input  logic [1:0]       wb_sel,
   input  logic [31:0]      alu_result,
   input  logic [31:0]      load_data,
   input  logic [2:0]       funct3,
   input  logic [31:0]      pc_plus4,
   output logic             RegWrite,
   output logic [4:0]       rd,
   output logic [31:0]      WriteData,
   output logic             wb_valid,
   output logic [CNT_W-1:0] retire_count
);

   logic [31:0] load_value;
   logic [31:0] result_next;
   logic        capture_next;

   logic        wb_valid_reg;
   logic        regwrite_reg;
   logic [4:0]  rd_reg;
   logic [31:0] data_reg;

   load_extend u_load_extend (
      .word   (load_data),
      .offset (alu_result[1:0]),
      .funct3 (funct3),
      .value  (load_value)
   );

   always_comb begin
      result_next = alu_result;
      case (wb_sel_e'(wb_sel))
         WB_SEL_ALU:  result_next = alu_result;
         WB_SEL_LOAD: result_next = load_value;
         WB_SEL_PC4:  result_next = pc_plus4;
         WB_SEL_RSVD: result_next = 32'h0;
      endcase
   end

   // Flush and stall both turn the incoming slot into a bubble; payload holds.
   assign capture_next = mem_valid & ~flush & ~mem_stall;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb_valid_reg <= 1'b0;
         regwrite_reg <= 1'b0;
         rd_reg       <= 5'd0;
         data_reg     <= 32'h0;
      end else begin
         wb_valid_reg <= capture_next;
         if (capture_next) begin
            regwrite_reg <= RegWrite_in;
            rd_reg       <= rd_in;
            data_reg     <= result_next;
         end
      end
   end

   assign wb_valid  = wb_valid_reg;
   assign rd        = rd_reg;
   assign WriteData = data_reg;
   // x0 is hardwired zero, so a write to it is suppressed here.
   assign RegWrite  = wb_valid_reg & regwrite_reg & (rd_reg != 5'd0);

`ifdef WB_RETIRE_COUNT_EN
   logic [CNT_W-1:0] retire_count_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         retire_count_reg <= '0;
      end else if (wb_valid_reg) begin
         retire_count_reg <= retire_count_reg + CNT_W'(1);
      end
   end

   assign retire_count = retire_count_reg;
`else
   assign retire_count = '0;
`endif

endmodule
